full_adder: RTL and testbench



---
 rtl/full_adder_if.sv | 25 ++
 rtl/full_adder.sv | 65 ++++++
 tb/tb_full_adder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder: inputs and valid strobe from the
// producer, combinational and registered results back to it.
interface full_adder_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             out_valid;

  modport master (
    output a, b, c, in_valid,
    input  sum, carry, sum_q, carry_q, out_valid
  );

  modport slave (
    input  a, b, c, in_valid,
    output sum, carry, sum_q, carry_q, out_valid
  );
endinterface

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry full adder with carry-in.
// Zero-latency sum/carry, plus a one-cycle registered copy with a valid strobe.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input logic        clk,
  input logic        rst,
  full_adder_if.slave bus
);

  logic [WIDTH-1:0] sum_c;
  logic             carry_c;

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_d;
  logic             carry_q;
  logic             valid_d;
  logic             valid_q;

  // Ripple chain of 1-bit full-adder cells; carry of cell i feeds cell i+1.
  always_comb begin : ripple
    logic [WIDTH:0] ci;
    ci    = '0;
    sum_c = '0;
    ci[0] = bus.c;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_c[i]  = bus.a[i] ^ bus.b[i] ^ ci[i];
      ci[i + 1] = (bus.a[i] & bus.b[i]) | (ci[i] & (bus.a[i] ^ bus.b[i]));
    end
    carry_c = ci[WIDTH];
  end

  // Capture on in_valid, otherwise hold the result and drop the strobe.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      sum_d   = sum_c;
      carry_d = carry_c;
      valid_d = 1'b1;
    end
  end

  // Output register; reset wins over a simultaneous in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sum       = sum_c;
  assign bus.carry     = carry_c;
  assign bus.sum_q     = sum_q;
  assign bus.carry_q   = carry_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH = 1, 8 and 32 side by side.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(1))  if1  ();
  full_adder_if #(.WIDTH(8))  if8  ();
  full_adder_if #(.WIDTH(32)) if32 ();

  full_adder #(.WIDTH(1))  u_w1  (.clk(clk), .rst(rst), .bus(if1));
  full_adder #(.WIDTH(8))  u_w8  (.clk(clk), .rst(rst), .bus(if8));
  full_adder #(.WIDTH(32)) u_w32 (.clk(clk), .rst(rst), .bus(if32));

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  // Stimulus per instance (0: W1, 1: W8, 2: W32)
  logic [63:0] ta [3];
  logic [63:0] tb_ [3];
  logic        tc [3];
  logic        tv [3];

  // Reference state of the registered outputs
  logic [63:0] m_sum   [3];
  logic        m_carry [3];
  logic        m_ov    [3];

  // WIDTH=1 truth table, index {a,b,c} -> {carry,sum}
  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  function automatic int unsigned wid(input int k);
    return (k == 0) ? 1 : (k == 1) ? 8 : 32;
  endfunction

  // {carry,sum} = a + b + c with operands reduced to w bits
  function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic c, input int unsigned w);
    logic [64:0] mask;
    logic [64:0] full;
    mask = (65'd1 << w) - 65'd1;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 65'(c);
    return full & ((mask << 1) | 65'd1);
  endfunction

  function automatic logic [64:0] obs_comb(input int k);
    case (k)
      0:       return (65'(if1.carry)  << 1)  | 65'(if1.sum);
      1:       return (65'(if8.carry)  << 8)  | 65'(if8.sum);
      default: return (65'(if32.carry) << 32) | 65'(if32.sum);
    endcase
  endfunction

  function automatic logic [64:0] obs_reg(input int k);
    case (k)
      0:       return (65'(if1.carry_q)  << 1)  | 65'(if1.sum_q);
      1:       return (65'(if8.carry_q)  << 8)  | 65'(if8.sum_q);
      default: return (65'(if32.carry_q) << 32) | 65'(if32.sum_q);
    endcase
  endfunction

  function automatic logic obs_ov(input int k);
    case (k)
      0:       return if1.out_valid;
      1:       return if8.out_valid;
      default: return if32.out_valid;
    endcase
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    if1.a  = ta[0][0:0];  if1.b  = tb_[0][0:0];  if1.c  = tc[0]; if1.in_valid  = tv[0];
    if8.a  = ta[1][7:0];  if8.b  = tb_[1][7:0];  if8.c  = tc[1]; if8.in_valid  = tv[1];
    if32.a = ta[2][31:0]; if32.b = tb_[2][31:0]; if32.c = tc[2]; if32.in_valid = tv[2];
  endtask

  task automatic chk_comb_all();
    for (int k = 0; k < 3; k++)
      check($sformatf("comb_w%0d", wid(k)), obs_comb(k), ref_add(ta[k], tb_[k], tc[k], wid(k)));
  endtask

  task automatic model_edge();
    logic [64:0] r;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_sum[k] = '0; m_carry[k] = 1'b0; m_ov[k] = 1'b0;
      end else if (tv[k]) begin
        r          = ref_add(ta[k], tb_[k], tc[k], wid(k));
        m_carry[k] = r[wid(k)];
        m_sum[k]   = 64'(r & ~(65'd1 << wid(k)));
        m_ov[k]    = 1'b1;
      end else begin
        m_ov[k] = 1'b0;
      end
    end
  endtask

  task automatic chk_reg_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reg_w%0d", wid(k)), obs_reg(k),
            (65'(m_carry[k]) << wid(k)) | 65'(m_sum[k]));
      check($sformatf("ov_w%0d", wid(k)), 65'(obs_ov(k)), 65'(m_ov[k]));
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then check
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk_reg_all();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      ta[k] = '0; tb_[k] = '0; tc[k] = 1'b0; tv[k] = 1'b0;
    end
    apply();

    // WIDTH=1 truth-table sweep, one combination per 5 ns
    for (int i = 0; i < 8; i++) begin
      ta[0] = 64'(i[2]); tb_[0] = 64'(i[1]); tc[0] = i[0];
      apply();
      #1;
      check($sformatf("tt_%0d", i), obs_comb(0), 65'(tt[i]));
      #4;
    end

    // Reset for two cycles
    rst = 1'b1;
    for (int k = 0; k < 3; k++) tv[k] = 1'b0;
    apply();
    tick();
    tick();

    // Single transaction 1+1+1 at WIDTH=1, then hold
    rst = 1'b0;
    ta[0] = 64'd1; tb_[0] = 64'd1; tc[0] = 1'b1; tv[0] = 1'b1;
    apply();
    #1 chk_comb_all();
    tick();
    check("w1_sum_q", 65'(if1.sum_q), 65'd1);
    check("w1_carry_q", 65'(if1.carry_q), 65'd1);
    check("w1_ov", 65'(if1.out_valid), 65'd1);
    tv[0] = 1'b0;
    apply();
    tick();
    check("w1_ov_drop", 65'(if1.out_valid), 65'd0);
    check("w1_hold", obs_reg(0), 65'h3);

    // WIDTH=8 directed boundaries
    ta[1] = 64'hFF; tb_[1] = 64'h01; tc[1] = 1'b0; apply();
    #1 check("w8_ff_01_0", obs_comb(1), 65'h100);
    ta[1] = 64'hFF; tb_[1] = 64'hFF; tc[1] = 1'b1; apply();
    #1 check("w8_ff_ff_1", obs_comb(1), 65'h1FF);
    ta[1] = 64'h12; tb_[1] = 64'h34; tc[1] = 1'b1; apply();
    #1 check("w8_12_34_1", obs_comb(1), 65'h047);
    ta[1] = 64'h00; tb_[1] = 64'h00; tc[1] = 1'b0; apply();
    #1 check("w8_zero", obs_comb(1), 65'h000);

    // WIDTH=8 streaming: four back-to-back results
    begin
      logic [7:0] sa [4] = '{8'h10, 8'hF0, 8'h7F, 8'hAA};
      logic [7:0] sb [4] = '{8'h20, 8'h20, 8'h01, 8'h55};
      logic       sc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
        ta[1] = 64'(sa[i]); tb_[1] = 64'(sb[i]); tc[1] = sc[i]; tv[1] = 1'b1;
        apply();
        #1 chk_comb_all();
        tick();
        check($sformatf("stream_ov_%0d", i), 65'(if8.out_valid), 65'd1);
      end
      tv[1] = 1'b0;
      apply();
      tick();
    end

    // Reset colliding with in_valid
    rst = 1'b1;
    ta[1] = 64'h80; tb_[1] = 64'h80; tc[1] = 1'b0; tv[1] = 1'b1;
    apply();
    #1 check("coll_comb", obs_comb(1), 65'h100);
    tick();
    check("coll_reg", obs_reg(1), 65'h0);
    check("coll_ov", 65'(if8.out_valid), 65'd0);
    check("coll_comb_in_rst", obs_comb(1), 65'h100);
    rst = 1'b0;

    // Randomized vectors with occasional reset and all-ones operands
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(63) == 0);
      for (int k = 0; k < 3; k++) begin
        ta[k]  = {$urandom, $urandom};
        tb_[k] = {$urandom, $urandom};
        if ($urandom_range(15) == 0) ta[k]  = '1;
        if ($urandom_range(15) == 0) tb_[k] = '1;
        tc[k] = 1'($urandom_range(1));
        tv[k] = ($urandom_range(3) != 0);
      end
      apply();
      #1 chk_comb_all();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
